// File: rtl/display_scanner.sv
// Four-digit time-multiplexed seven-segment scanner with per-slot ghost
// blanking, frame-synchronous input snapshot and optional leading-zero blanking.
module display_scanner #(
    parameter int DIV   = 100000,
    parameter int BLANK = 1000
) (
    input  logic        clkin,
    input  logic        greset,
    input  logic [15:0] value,
    input  logic [3:0]  dig_en,
    input  logic [3:0]  dp_en,
    input  logic        lzb,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic [1:0]  digsel,
    output logic        frame
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   value_s_q, value_s_d;
    logic [3:0]    dig_en_s_q, dig_en_s_d;
    logic [3:0]    dp_en_s_q, dp_en_s_d;
    logic          lzb_s_q, lzb_s_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [3:0]    an_q, an_d;
    logic [1:0]    digsel_q, digsel_d;
    logic          frame_q, frame_d;

    logic          wrap_s;
    logic          frame_wrap_s;
    logic [3:0]    nibble_s;
    logic          suppress_s;
    logic          active_s;
    logic          visible_s;

    function automatic logic [6:0] hex_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            4'hF:    s = 7'b0001110;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Slot/digit sequencing, frame snapshot, and outputs derived from post-edge state
    always_comb begin
        wrap_s       = (cnt_q == CW'(DIV - 1));
        frame_wrap_s = wrap_s && (idx_q == 2'd3);

        if (wrap_s) begin
            cnt_d = {CW{1'b0}};
            idx_d = idx_q + 2'd1;
        end else begin
            cnt_d = cnt_q + CW'(1);
            idx_d = idx_q;
        end

        if (frame_wrap_s) begin
            value_s_d  = value;
            dig_en_s_d = dig_en;
            dp_en_s_d  = dp_en;
            lzb_s_d    = lzb;
        end else begin
            value_s_d  = value_s_q;
            dig_en_s_d = dig_en_s_q;
            dp_en_s_d  = dp_en_s_q;
            lzb_s_d    = lzb_s_q;
        end
        frame_d = frame_wrap_s;

        // A digit is a leading zero when it and every higher nibble are zero
        case (idx_d)
            2'd0: begin
                nibble_s   = value_s_d[3:0];
                suppress_s = 1'b0;
            end
            2'd1: begin
                nibble_s   = value_s_d[7:4];
                suppress_s = (value_s_d[15:4] == 12'h000);
            end
            2'd2: begin
                nibble_s   = value_s_d[11:8];
                suppress_s = (value_s_d[15:8] == 8'h00);
            end
            2'd3: begin
                nibble_s   = value_s_d[15:12];
                suppress_s = (value_s_d[15:12] == 4'h0);
            end
            default: begin
                nibble_s   = 4'h0;
                suppress_s = 1'b0;
            end
        endcase

        active_s  = (cnt_d >= CW'(BLANK));
        visible_s = dig_en_s_d[idx_d] && !(lzb_s_d && suppress_s);

        if (active_s && visible_s) begin
            an_d  = ~(4'b0001 << idx_d);
            seg_d = hex_decode(nibble_s);
            dp_d  = ~dp_en_s_d[idx_d];
        end else begin
            an_d  = 4'hF;
            seg_d = 7'h7F;
            dp_d  = 1'b1;
        end
        digsel_d = idx_d;
    end

    // State and registered output flops with synchronous reset
    always_ff @(posedge clkin) begin
        if (greset) begin
            cnt_q      <= {CW{1'b0}};
            idx_q      <= 2'd0;
            value_s_q  <= 16'h0000;
            dig_en_s_q <= 4'h0;
            dp_en_s_q  <= 4'h0;
            lzb_s_q    <= 1'b0;
            seg_q      <= 7'h7F;
            dp_q       <= 1'b1;
            an_q       <= 4'hF;
            digsel_q   <= 2'd0;
            frame_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            value_s_q  <= value_s_d;
            dig_en_s_q <= dig_en_s_d;
            dp_en_s_q  <= dp_en_s_d;
            lzb_s_q    <= lzb_s_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
            digsel_q   <= digsel_d;
            frame_q    <= frame_d;
        end
    end

    assign seg    = seg_q;
    assign dp     = dp_q;
    assign an     = an_q;
    assign digsel = digsel_q;
    assign frame  = frame_q;

endmodule
